// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared state, master id and width definitions for the memory bus arbiter
package cpu_bus_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;
  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;
  typedef enum logic [1:0] {IDLE = ST_IDLE, OWN0 = ST_OWN0, OWN1 = ST_OWN1} state_e;
  function automatic state_e own_of(input logic m);
    return m ? OWN1 : OWN0;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_burst_counter.sv
// burst_counter: per-tenure transfer counter that wraps at MAX_BURST-1
module burst_counter #(
  parameter int MAX_BURST = 4,
  localparam int W = $clog2(MAX_BURST + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc = cnt_q == W'(MAX_BURST - 1);
  always_comb cnt_d = clr ? '0 : inc ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin, burst-capped sharing of one synchronous memory port between two masters
module mem_bus_arbiter import cpu_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_write,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic [DATA_W-1:0] to_memory,
  input  logic [DATA_W-1:0] from_memory
);
  state_e state_q, state_d;
  logic last_q, last_d, rd_pend_q, rd_pend_d, rd_owner_q, rd_owner_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic own0, own1, own_req, oth_req, own_write, xfer, tc, clr;
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign own_req = own0 ? m0_req : own1 ? m1_req : 1'b0;
  assign oth_req = own0 ? m1_req : m0_req;
  assign own_write = own0 ? m0_write : m1_write;
  assign xfer = own_req;
  burst_counter #(.MAX_BURST(MAX_BURST)) u_cnt (
    .clk(clk), .rst(reset), .clr(clr), .inc(xfer), .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = (m0_req && m1_req) ? own_of(!last_q) : m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
    else if (!own_req)
      state_d = oth_req ? own_of(!own1) : IDLE;
    else if (tc && oth_req)
      state_d = own_of(!own1);
    clr = state_d != state_q;
    last_d = state_d == OWN0 ? M_CPU : state_d == OWN1 ? M_AUX : last_q;
    rd_pend_d = xfer && !own_write;
    rd_owner_d = own1;
  end
  assign m0_gnt = own0;
  assign m1_gnt = own1;
  assign address = own0 ? m0_addr : own1 ? m1_addr : '0;
  assign to_memory = own0 ? m0_wdata : own1 ? m1_wdata : '0;
  assign write = own_req && own_write;
  // read data returns to whoever issued the read, even after the grant moved on
  assign m0_rvalid = rd_pend_q && rd_owner_q == M_CPU;
  assign m1_rvalid = rd_pend_q && rd_owner_q == M_AUX;
  assign m0_rdata = m0_rvalid ? from_memory : m0_rdata_q;
  assign m1_rdata = m1_rvalid ? from_memory : m1_rdata_q;
  assign m0_rdata_d = m0_rdata;
  assign m1_rdata_d = m1_rdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      last_q <= M_AUX;
      rd_pend_q <= 1'b0;
      rd_owner_q <= M_CPU;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rd_pend_q <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic against an owner/tenure reference model
module tb_mem_bus_arbiter;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 0, m1_req = 0, m0_write = 0, m1_write = 0;
  logic [7:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, write;
  logic [7:0] m0_rdata, m1_rdata, address, to_memory, from_memory;
  logic [7:0] mem [256];
  int n_cmp = 0, n_bad = 0;
  int own, cnt, lst, pown;
  bit pend;
  logic [7:0] pdata, ex_addr, ex_tm, ex_rd0, ex_rd1;
  logic ex_g0, ex_g1, ex_rv0, ex_rv1, ex_wr;
  logic [7:0] ref_mem [256];

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_write(m0_write), .m1_write(m1_write), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .address(address), .write(write),
    .to_memory(to_memory), .from_memory(from_memory)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
    mem[8'h10] = 8'hA5;
    forever begin
      @(posedge clk);
      if (write) mem[address] <= to_memory;
      from_memory <= mem[address];
    end
  end

  function automatic logic rq(input int i);
    return i == 1 ? m1_req : m0_req;
  endfunction
  function automatic logic wr(input int i);
    return i == 1 ? m1_write : m0_write;
  endfunction
  function automatic logic [7:0] ad(input int i);
    return i == 1 ? m1_addr : m0_addr;
  endfunction
  function automatic logic [7:0] wd(input int i);
    return i == 1 ? m1_wdata : m0_wdata;
  endfunction

  task automatic model_reset();
    own = -1; cnt = 0; lst = 1; pend = 0; pown = 0; pdata = 0;
    ex_rd0 = 0; ex_rd1 = 0;
  endtask

  task automatic calc_exp();
    ex_g0 = own == 0;
    ex_g1 = own == 1;
    ex_addr = own >= 0 ? ad(own) : 8'h00;
    ex_tm = own >= 0 ? wd(own) : 8'h00;
    ex_wr = own >= 0 ? (rq(own) & wr(own)) : 1'b0;
    ex_rv0 = pend && pown == 0;
    ex_rv1 = pend && pown == 1;
    if (ex_rv0) ex_rd0 = pdata;
    if (ex_rv1) ex_rd1 = pdata;
  endtask

  task automatic advance();
    int nxt;
    if (reset) begin model_reset(); return; end
    pend = 0;
    if (own >= 0 && rq(own)) begin
      if (wr(own)) ref_mem[ad(own)] = wd(own);
      else begin pend = 1; pown = own; pdata = ref_mem[ad(own)]; end
    end
    nxt = own;
    if (own < 0) nxt = (m0_req && m1_req) ? 1 - lst : m0_req ? 0 : m1_req ? 1 : -1;
    else if (!rq(own)) nxt = rq(1 - own) ? 1 - own : -1;
    else begin
      cnt++;
      if (cnt == MAXB) begin
        cnt = 0;
        if (rq(1 - own)) nxt = 1 - own;
      end
    end
    if (nxt != own) begin
      cnt = 0;
      if (nxt >= 0) lst = nxt;
    end
    own = nxt;
  endtask

  task automatic drive(input bit r0, input logic [7:0] a0, input bit w0, input logic [7:0] d0,
                       input bit r1, input logic [7:0] a1, input bit w1, input logic [7:0] d1);
    m0_req = r0; m0_addr = a0; m0_write = w0; m0_wdata = d0;
    m1_req = r1; m1_addr = a1; m1_write = w1; m1_wdata = d1;
    #1;
    calc_exp();
  endtask

  task automatic tick();
    advance();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    n_cmp++; if ({address, write, to_memory} !== 17'd0) begin n_bad++; $display("FAIL reset_bus: got addr %h wr %b data %h want 0", address, write, to_memory); end
    n_cmp++; if ({m0_rdata, m1_rdata} !== 16'd0) begin n_bad++; $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    drive(1, 8'h10, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (m0_gnt !== 1'b0) begin n_bad++; $display("FAIL read_gnt_early: got %b want 0", m0_gnt); end
    tick();
    drive(1, 8'h10, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL read_gnt: got %b want 1", m0_gnt); end
    n_cmp++; if (address !== 8'h10) begin n_bad++; $display("FAIL read_addr: got %h want 10", address); end
    tick();
    drive(0, 8'h10, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (m0_rvalid !== 1'b1) begin n_bad++; $display("FAIL read_rvalid: got %b want 1", m0_rvalid); end
    n_cmp++; if (m0_rdata !== 8'hA5) begin n_bad++; $display("FAIL read_rdata: got %h want a5", m0_rdata); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (m0_rvalid !== 1'b0) begin n_bad++; $display("FAIL read_rvalid_pulse: got %b want 0", m0_rvalid); end
    n_cmp++; if (m0_rdata !== 8'hA5) begin n_bad++; $display("FAIL read_rdata_hold: got %h want a5", m0_rdata); end
    tick();
  endtask

  task automatic test_tie_and_round_robin();
    do_reset();
    drive(1, 8'h01, 0, 0, 1, 8'h02, 0, 0);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1, 8'(i), 0, 0, 1, 8'(i + 64), 0, 0);
      if (i == 0) begin
        n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL tie: got m0 %b m1 %b want m0 1 m1 0", m0_gnt, m1_gnt); end
      end
      n_cmp++;
      if (m0_gnt !== (i < 4 || i >= 8) || m1_gnt !== (i >= 4 && i < 8)) begin
        n_bad++; $display("FAIL rr_cycle%0d: got m0 %b m1 %b want m0 %b", i, m0_gnt, m1_gnt, (i < 4 || i >= 8));
      end
      n_cmp++; if ((m0_gnt ^ m1_gnt) !== 1'b1) begin n_bad++; $display("FAIL rr_one_owner%0d: got m0 %b m1 %b want exactly one", i, m0_gnt, m1_gnt); end
      tick();
    end
  endtask

  task automatic test_drop_handover();
    do_reset();
    drive(0, 0, 0, 0, 1, 8'h30, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 8'h31, 0, 0);
    n_cmp++; if (m1_gnt !== 1'b1) begin n_bad++; $display("FAIL drop_m1_gnt: got %b want 1", m1_gnt); end
    tick();
    drive(0, 0, 0, 0, 1, 8'h32, 0, 0);
    tick();
    drive(1, 8'h40, 0, 0, 0, 0, 0, 0);
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b01) begin n_bad++; $display("FAIL drop_same_cycle: got m0 %b m1 %b want m0 0 m1 1", m0_gnt, m1_gnt); end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0, 1, 8'h33, 0, 0);
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== (i < 4 ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL drop_fresh_burst%0d: got m0 %b m1 %b want m0 %b", i, m0_gnt, m1_gnt, i < 4);
      end
      tick();
    end
  endtask

  task automatic test_write_then_read();
    int wcount = 0;
    do_reset();
    drive(0, 0, 0, 0, 1, 8'h80, 1, 8'h3C);
    tick();
    drive(0, 0, 0, 0, 1, 8'h80, 1, 8'h3C);
    wcount += int'(write);
    n_cmp++; if ({write, address, to_memory} !== {1'b1, 8'h80, 8'h3C}) begin n_bad++; $display("FAIL wr_bus: got wr %b addr %h data %h want 1 80 3c", write, address, to_memory); end
    tick();
    drive(1, 8'h80, 0, 0, 0, 8'h80, 1, 8'h3C);
    wcount += int'(write);
    tick();
    drive(1, 8'h80, 0, 0, 0, 0, 0, 0);
    wcount += int'(write);
    n_cmp++; if (m0_gnt !== 1'b1) begin n_bad++; $display("FAIL wr_rd_gnt: got %b want 1", m0_gnt); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    wcount += int'(write);
    n_cmp++; if (wcount !== 1) begin n_bad++; $display("FAIL wr_once: got %0d write cycles want 1", wcount); end
    n_cmp++; if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 8'h3C}) begin n_bad++; $display("FAIL wr_readback: got rv %b%b data %h want 10 3c", m0_rvalid, m1_rvalid, m0_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(1, 8'h20, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 8'h21, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 8'h22, 0, 0, 1, 8'h50, 0, 0);
    n_cmp++; if ({m0_gnt, m0_rvalid} !== 2'b11) begin n_bad++; $display("FAIL mid_pre: got gnt %b rv %b want 1 1", m0_gnt, m0_rvalid); end
    reset = 1'b1;
    #1;
    model_reset();
    calc_exp();
    n_cmp++; if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin n_bad++; $display("FAIL mid_clear: got gnt %b%b rv %b%b want 0000", m0_gnt, m1_gnt, m0_rvalid, m1_rvalid); end
    n_cmp++; if ({address, write} !== 9'd0) begin n_bad++; $display("FAIL mid_bus: got addr %h wr %b want 0", address, write); end
    tick();
    reset = 1'b0;
    drive(1, 8'h23, 0, 0, 1, 8'h51, 0, 0);
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_bad++; $display("FAIL mid_idle: got %b%b want 00", m0_gnt, m1_gnt); end
    tick();
    drive(1, 8'h23, 0, 0, 1, 8'h51, 0, 0);
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_bad++; $display("FAIL mid_tie: got m0 %b m1 %b want m0 1 m1 0", m0_gnt, m1_gnt); end
    tick();
  endtask

  task automatic test_random();
    bit r0 = 0, r1 = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) r0 = !r0;
      if ($urandom_range(3) == 0) r1 = !r1;
      drive(r0, 8'($urandom_range(20)), 1'($urandom_range(1)), 8'($urandom),
            r1, 8'($urandom_range(20)), 1'($urandom_range(1)), 8'($urandom));
      n_cmp++; if ({m0_gnt, m1_gnt} !== {ex_g0, ex_g1}) begin n_bad++; $display("FAIL rnd_gnt@%0d: got %b%b want %b%b", i, m0_gnt, m1_gnt, ex_g0, ex_g1); end
      n_cmp++; if ({address, write, to_memory} !== {ex_addr, ex_wr, ex_tm}) begin n_bad++; $display("FAIL rnd_bus@%0d: got %h %b %h want %h %b %h", i, address, write, to_memory, ex_addr, ex_wr, ex_tm); end
      n_cmp++; if ({m0_rvalid, m1_rvalid} !== {ex_rv0, ex_rv1}) begin n_bad++; $display("FAIL rnd_rvalid@%0d: got %b%b want %b%b", i, m0_rvalid, m1_rvalid, ex_rv0, ex_rv1); end
      n_cmp++; if ({m0_rdata, m1_rdata} !== {ex_rd0, ex_rd1}) begin n_bad++; $display("FAIL rnd_rdata@%0d: got %h %h want %h %h", i, m0_rdata, m1_rdata, ex_rd0, ex_rd1); end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
    ref_mem[8'h10] = 8'hA5;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_tie_and_round_robin();
    test_drop_handover();
    test_write_then_read();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter sharing the single 8-bit memory port between the `cpu` instance (master 0) and a second requester such as a program loader or DMA engine (master 1). It grants the port to one master at a time using round-robin with a burst cap, muxes address, write strobe and write data to memory, and routes read data back to the master that issued the read. It sits between the CPU/loader and the memory model, in place of the direct `address`/`write`/`to_memory`/`from_memory` wiring.

## Interface
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.
- `MAX_BURST`, default 4: maximum consecutive transfers for one owner while the other master is waiting; must be at least 1.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `m0_req`, `m1_req` in 1: transfer request, held until the master is done.
- `m0_addr`, `m1_addr` in ADDR_W: transfer address.
- `m0_write`, `m1_write` in 1: 1 = write, 0 = read.
- `m0_wdata`, `m1_wdata` in DATA_W: write data.
- `m0_gnt`, `m1_gnt` out 1: registered grant; at most one is high.
- `m0_rdata`, `m1_rdata` out DATA_W: read data.
- `m0_rvalid`, `m1_rvalid` out 1: one-cycle pulse marking valid rdata.
- `address` out ADDR_W: memory address.
- `write` out 1: memory write strobe.
- `to_memory` out DATA_W: memory write data.
- `from_memory` in DATA_W: memory read data, valid one cycle after the address is presented (synchronous memory).

## Operation
- FSM states: IDLE, OWN0, OWN1. A `last` bit records the most recent owner.
- A transfer occurs in every cycle where `mX_gnt && mX_req` for the owner.
- In IDLE:
  - Only one master requesting: go to its OWN state.
  - Both masters requesting: go to the master that is not `last`.
  - No requests: stay in IDLE.
- In OWNx:
  - If `mX_req` is low: go to OWNy when `my_req` is high, otherwise to IDLE.
  - If the transfer just completed is the MAX_BURST-th and `my_req` is high: go to OWNy.
  - Otherwise stay in OWNx.
- `burst_cnt` counts transfers in the current tenure:
  - Cleared on every state change.
  - Cleared on wrap when the cap is reached but the other master is not requesting; the owner keeps the port.
- `last` updates whenever an OWN state is entered.
- Muxing:
  - `address`, `to_memory` and `write` come combinationally from the owner's inputs.
  - `write` = owner `mX_write` & `mX_req` & `mX_gnt`.
  - In IDLE, `address`, `to_memory` and `write` are all 0.
- Read return: registers `rd_pend` and `rd_owner` capture each read transfer. On the next cycle, `from_memory` drives the owner's `mX_rdata` and pulses `mX_rvalid`. This holds even if the grant has since moved.
- The non-owner's `rdata` holds its last value.
- No arithmetic beyond `burst_cnt`. `burst_cnt` is `$clog2(MAX_BURST+1)` bits and never exceeds MAX_BURST-1 after an update.

## Timing
- Reset values:
  - state IDLE, `last`=1 (so master 0 wins the first tie), `burst_cnt`=0.
  - All `gnt`=0, all `rvalid`=0, all `rdata`=0, `rd_pend`=0.
  - `address`=0, `write`=0, `to_memory`=0.
- Grant latency: a request sampled at edge N gives `gnt` high after edge N (from IDLE). The first transfer occurs in that cycle.
- Handover: the last transfer of the old owner happens in cycle K. The new owner's `gnt` rises after edge K; there are no idle cycles between owners.
- Read latency: the address is presented in cycle K; `rvalid` and `rdata` are valid in cycle K+1.
- A master dropping `req` in the same cycle the other raises it: the handover happens at the next edge.
- Reset mid-burst: all state clears immediately, and any pending read `rvalid` is discarded.

## Structure
- Shared package `cpu_bus_pkg`:
  - state encoding constants `ST_IDLE`=2'd0, `ST_OWN0`=2'd1, `ST_OWN1`=2'd2.
  - master ID constants `M_CPU`=0, `M_AUX`=1.
  - default `DATA_W`/`ADDR_W`.
- One sub-module, `burst_counter`: a counter with clear, increment and terminal-count output at MAX_BURST-1. The FSM, muxing and read-return logic stay in `mem_bus_arbiter`.

## Test plan
- Only `m0_req`, a read of 0x10 with memory[0x10]=0xA5:
  - `m0_gnt` rises one cycle after the request.
  - `m0_rvalid` pulses one cycle after the transfer, with `m0_rdata`=0xA5.
- `m0_req` and `m1_req` raised in the same cycle after reset: `m0_gnt` is granted first and `m1_gnt` stays 0.
- Both masters request continuously with MAX_BURST=4:
  - Grants alternate every 4 transfers (m0×4, m1×4, m0×4).
  - No cycle has both grants high, and no idle cycle occurs between owners.
- m1 owns the port and drops `req` after 2 transfers while `m0_req` is high: `m0_gnt` rises at the next edge and `burst_cnt` restarts at 0.
- m1 writes 0x3C to 0x80, then m0 reads 0x80:
  - `write`=1 for exactly one cycle with `address`=0x80 and `to_memory`=0x3C.
  - m0 then receives `m0_rdata`=0x3C.
- Assert `reset` in the middle of an m0 read burst:
  - All grants, `rvalid`, `address` and `write` go to 0 immediately.
  - After release, a tie is won by m0.
